// File: rtl/dff_checker.sv
// dff_checker: response-side checker for a D flip-flop with active-low clear/preset.
//   Observes the monitored flop (never drives it), keeps a reference bit and compares Q/Qb
//   once per clk edge; reports a mismatch pulse, a sticky error, and error/check counters.
// Ports:
//   clk, clr (async active-low checker reset); d, dut_clr, dut_pre, q, qb (observed flop);
//   mismatch (1-cycle pulse), err (sticky), err_count[7:0] (saturating),
//   check_count[15:0] (wrapping), unk (flop state undefined).
// Option: define DFF_CHECKER_QB_CHECK_EN to also require qb == ~q on every
//   compare outside the clear+preset (both-low) case.
module dff_checker (
  input  logic        clk,
  input  logic        clr,
  input  logic        d,
  input  logic        dut_clr,
  input  logic        dut_pre,
  input  logic        q,
  input  logic        qb,
  output logic        mismatch,
  output logic        err,
  output logic [7:0]  err_count,
  output logic [15:0] check_count,
  output logic        unk
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_CHECK = 2'd1,
    S_UNK   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        exp_q, exp_d;
  logic        mismatch_q, mismatch_d;
  logic        err_q, err_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [15:0] check_count_q, check_count_d;

  logic both_low, both_high;
  logic do_cmp, cmp_fail, exp_bit;

  assign both_low  = !dut_clr && !dut_pre;
  assign both_high = dut_clr && dut_pre;

  // Value the flop must show at this edge. Clear/preset are asynchronous on the
  // monitored flop, so levels seen at this edge override the stored reference.
  always_comb begin
    exp_bit  = exp_q;
    cmp_fail = 1'b0;
    if (both_low) begin
      // Both outputs are forced high; qb is checked here regardless of the option.
      cmp_fail = !(q && qb);
    end else begin
      if (!dut_clr) begin
        exp_bit = 1'b0;
      end else if (!dut_pre) begin
        exp_bit = 1'b1;
      end
      cmp_fail = (q != exp_bit);
`ifdef DFF_CHECKER_QB_CHECK_EN
      // A qb fault on top of a q fault is still a single failure.
      cmp_fail = cmp_fail || (qb == q);
`else
      cmp_fail = cmp_fail;
`endif
    end
  end

  // Next state, reference update and compare enable.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    do_cmp  = 1'b0;

    // Reference follows the flop; a both-low edge leaves it untouched because the
    // flop's post-release value is decided by the release edge.
    if (!dut_clr && dut_pre) begin
      exp_d = 1'b0;
    end else if (dut_clr && !dut_pre) begin
      exp_d = 1'b1;
    end else if (both_high) begin
      exp_d = d;
    end

    case (state_q)
      S_INIT: begin
        state_d = both_low ? S_UNK : S_CHECK;
      end
      S_CHECK: begin
        do_cmp = 1'b1;
        if (both_low) begin
          state_d = S_UNK;
        end
      end
      S_UNK: begin
        // Release edge: flop content is unknowable, so skip it and resync from d.
        if (both_high) begin
          state_d = S_CHECK;
        end else begin
          do_cmp = 1'b1;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_comb begin
    mismatch_d    = do_cmp && cmp_fail;
    err_d         = err_q || mismatch_d;
    err_count_d   = err_count_q;
    if (mismatch_d && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
    check_count_d = do_cmp ? (check_count_q + 16'd1) : check_count_q;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q       <= S_INIT;
      exp_q         <= 1'b0;
      mismatch_q    <= 1'b0;
      err_q         <= 1'b0;
      err_count_q   <= 8'd0;
      check_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      exp_q         <= exp_d;
      mismatch_q    <= mismatch_d;
      err_q         <= err_d;
      err_count_q   <= err_count_d;
      check_count_q <= check_count_d;
    end
  end

  assign mismatch    = mismatch_q;
  assign err         = err_q;
  assign err_count   = err_count_q;
  assign check_count = check_count_q;
  assign unk         = (state_q == S_UNK);

endmodule

// File: doc/dff_checker.md
DFF_CHECKER -- requirements
Module: dff_checker

Interface
REQ-001 The block SHALL have the following ports, clock and reset first:
- clk  input  1  single clock; all sequential logic on its rising edge.
- clr  input  1  checker reset, asynchronous, active-low.
- d  input  1  data input as driven to the monitored D flip-flop.
- dut_clr  input  1  monitored flop's clear, active-low.
- dut_pre  input  1  monitored flop's preset, active-low.
- q  input  1  monitored flop's Q output.
- qb  input  1  monitored flop's Qb output.
- mismatch  output  1  one-cycle pulse on a failed check.
- err  output  1  sticky error flag.
- err_count  output  8  failed-check count.
- check_count  output  16  performed-check count.
- unk  output  1  high while the monitored flop's state is undefined.
REQ-002 The block SHALL be the response end of the D-flop stimulus interface: it observes the DUT and never drives it.

Function
REQ-003 All inputs SHALL be sampled on the rising edge of clk only; dut_clr and dut_pre are treated as levels at that edge.
REQ-004 The block SHALL keep a model bit exp, updated at every edge after the compare: dut_clr=0 & dut_pre=1 -> 0; dut_clr=1 & dut_pre=0 -> 1; both 1 -> d.
REQ-005 The expected value at edge k+1 SHALL be selected in this order:
- dut_clr=0 & dut_pre=0 -> q=1 and qb=1.
- dut_clr=0 only -> q=0.
- dut_pre=0 only -> q=1.
- otherwise -> q = exp loaded at edge k.
REQ-006 The FSM SHALL have three states:
- INIT: after reset; loads exp, performs no compare; moves to CHECK on the next edge.
- CHECK: compares each edge.
- UNK: entered when an edge samples both dut_clr=0 and dut_pre=0.
REQ-007 While in UNK, the both-low compare of REQ-005 SHALL still run; the first edge with both high SHALL skip the compare, reload exp from d, and return to CHECK.
REQ-008 unk SHALL be 1 exactly while the state is UNK.
REQ-009 Each performed compare SHALL increment check_count, modulo 2^16 (wraps 65535 -> 0).
REQ-010 On a failed compare, the block SHALL in the next cycle:
- assert mismatch for exactly one cycle;
- set err, which stays set until reset;
- increment err_count, saturating at 255.
REQ-011 Simultaneous failure and check_count wrap SHALL both take effect in the same cycle.

Reset
REQ-012 clr=0 SHALL asynchronously force: state=INIT, exp=0, mismatch=0, err=0, err_count=0, check_count=0, unk=0.
REQ-013 Reset asserted mid-operation SHALL discard any pending compare; the first edge after release behaves as INIT.

Configuration
REQ-014 With DFF_CHECKER_QB_CHECK_EN defined:
- every compare outside the both-low case also requires qb = ~q;
- a qb violation counts as one failure, even if q is also wrong.
REQ-015 Without DFF_CHECKER_QB_CHECK_EN, qb SHALL be ignored, except in the both-low case of REQ-005.

Verification
REQ-016 A bench SHALL cover the following directed scenarios:
- Normal capture: dut_clr=dut_pre=1; drive d=1, correct DUT q=1 next edge -> mismatch=0, check_count +1 per edge.
- Clear and preset: dut_clr=0 for 3 edges with q=0, then dut_pre=0 for 3 edges with q=1 -> no mismatch, err=0.
- Fault injection: force q opposite of expected on one edge -> mismatch pulses one cycle, err=1 sticky, err_count=1.
- Both-low race: dut_clr=dut_pre=0 with q=qb=1 for 2 edges, release both -> unk=1 through release edge, that edge not counted, then CHECK resumes.
- Saturation and wrap: 300 forced failures -> err_count holds 255; 65536 checks -> check_count returns to 0.
- Qb check: q correct, qb=q -> mismatch only when DFF_CHECKER_QB_CHECK_EN is defined.
- Reset: clr=0 mid-run -> all outputs 0 immediately; first edge after release does no compare.
